cache_mesi_array_ctrl: RTL

// - Next-generation MESI controller for the shared L2: holds the MESI state of every line (NUM_SETS x NUM_WAYS), not one.
// - Takes one processor/snoop request per transaction. Drives a bus op and an L2->L1 message as registered one-cycle pulses.
// - Stalls on I-state misses until the bus transaction completes; snoop result selects E or S.
// - Sits between the L2 tag/LRU logic (supplies set/way) and the bus/L1 interfaces.

---
 rtl/cache_mesi_array_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_mesi_array_ctrl.sv
// ---------------------------------------------------------------------------
// cache_mesi_array_ctrl
//
// MESI coherence controller for the shared L2. It holds the MESI state of
// every line (NUM_SETS x NUM_WAYS) and services one processor or snoop
// request per transaction. Bus ops and L2->L1 messages leave as registered
// one-cycle pulses.
//
// Ports:
//   clk, rstb               clock (posedge) and async active-low reset
//   req_valid / req_ready   request handshake; ready only while IDLE
//   req_cmd/set/way         command and target line (set/way from tag/LRU)
//   bus_done                outstanding miss has completed on the bus
//   snoop_hit / snoop_hitm  snoop result, sampled together with bus_done
//   bus_valid / bus_op      one-cycle bus operation pulse
//   resp_valid / l1_msg     one-cycle response pulse to the L1
//   state_out / err         new line state and protocol error (with resp)
//   dbg_set/dbg_way         debug read index
//   dbg_state               combinational MESI state of the debug line
// ---------------------------------------------------------------------------
module cache_mesi_array_ctrl #(
  parameter  int NUM_SETS = 16,
  parameter  int NUM_WAYS = 4,
  localparam int SET_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  input  logic             bus_done,
  input  logic             snoop_hit,
  input  logic             snoop_hitm,
  output logic             bus_valid,
  output logic [2:0]       bus_op,
  output logic             resp_valid,
  output logic [2:0]       l1_msg,
  output logic [1:0]       state_out,
  output logic             err,
  input  logic [SET_W-1:0] dbg_set,
  input  logic [WAY_W-1:0] dbg_way,
  output logic [1:0]       dbg_state
);

  // Request commands
  localparam logic [2:0] CMD_RD      = 3'd1;
  localparam logic [2:0] CMD_WR      = 3'd2;
  localparam logic [2:0] CMD_SNP_RD  = 3'd3;
  localparam logic [2:0] CMD_SNP_RDX = 3'd4;
  localparam logic [2:0] CMD_SNP_INV = 3'd5;
  localparam logic [2:0] CMD_CLR     = 3'd6;

  // Bus operations
  localparam logic [2:0] BUS_NULL  = 3'd0;
  localparam logic [2:0] BUS_READ  = 3'd1;
  localparam logic [2:0] BUS_WRITE = 3'd2;
  localparam logic [2:0] BUS_INV   = 3'd3;
  localparam logic [2:0] BUS_RWIM  = 3'd4;

  // L2 -> L1 messages
  localparam logic [2:0] MSG_NULL     = 3'd0;
  localparam logic [2:0] MSG_GETLINE  = 3'd1;
  localparam logic [2:0] MSG_SENDLINE = 3'd2;
  localparam logic [2:0] MSG_INVLINE  = 3'd3;
  localparam logic [2:0] MSG_EVICT    = 3'd4;

  // MESI encodings
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_MISS_WAIT,
    FSM_CLEAR
  } fsm_e;

  fsm_e fsm_q, fsm_d;

  // Packed so the whole array can be copied as the default next value.
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][1:0] state_q, state_d;

  logic [SET_W-1:0] miss_set_q, miss_set_d;
  logic [WAY_W-1:0] miss_way_q, miss_way_d;
  logic             miss_wr_q, miss_wr_d;
  logic [SET_W-1:0] clr_idx_q, clr_idx_d;

  logic             bus_valid_q, bus_valid_d;
  logic [2:0]       bus_op_q, bus_op_d;
  logic             resp_valid_q, resp_valid_d;
  logic [2:0]       l1_msg_q, l1_msg_d;
  logic [1:0]       state_out_q, state_out_d;
  logic             err_q, err_d;

  logic [1:0]       cur_state;
  logic [1:0]       new_state;

  assign cur_state = state_q[req_set][req_way];

  // Next-state / output decode. All pulse outputs default to zero so every
  // response and bus op lasts exactly one cycle.
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    miss_set_d   = miss_set_q;
    miss_way_d   = miss_way_q;
    miss_wr_d    = miss_wr_q;
    clr_idx_d    = clr_idx_q;
    bus_op_d     = BUS_NULL;
    resp_valid_d = 1'b0;
    l1_msg_d     = MSG_NULL;
    state_out_d  = ST_I;
    err_d        = 1'b0;
    new_state    = cur_state;

    unique case (fsm_q)
      FSM_IDLE: begin
        if (req_valid) begin
          case (req_cmd)
            CMD_RD, CMD_WR: begin
              if (cur_state == ST_I) begin
                // Miss: remember the line and go fetch it.
                miss_set_d = req_set;
                miss_way_d = req_way;
                miss_wr_d  = (req_cmd == CMD_WR);
                bus_op_d   = (req_cmd == CMD_WR) ? BUS_RWIM : BUS_READ;
                fsm_d      = FSM_MISS_WAIT;
              end else begin
                // Hit: a write upgrades to M; from S other copies must go.
                new_state = (req_cmd == CMD_WR) ? ST_M : cur_state;
                if (req_cmd == CMD_WR && cur_state == ST_S) begin
                  bus_op_d = BUS_INV;
                end
                resp_valid_d = 1'b1;
                l1_msg_d     = MSG_SENDLINE;
              end
            end
            CMD_SNP_RD: begin
              resp_valid_d = 1'b1;
              if (cur_state == ST_M) begin
                new_state = ST_S;
                bus_op_d  = BUS_WRITE;
                l1_msg_d  = MSG_GETLINE;
              end else if (cur_state != ST_I) begin
                new_state = ST_S;
              end
            end
            CMD_SNP_RDX: begin
              resp_valid_d = 1'b1;
              new_state    = ST_I;
              if (cur_state == ST_M) begin
                bus_op_d = BUS_WRITE;
                l1_msg_d = MSG_EVICT;
              end else if (cur_state != ST_I) begin
                l1_msg_d = MSG_INVLINE;
              end
            end
            CMD_SNP_INV: begin
              resp_valid_d = 1'b1;
              // Invalidate against a modified line means the bus protocol
              // was broken: keep the dirty data and flag it.
              if (cur_state == ST_M) begin
                err_d = 1'b1;
              end else if (cur_state != ST_I) begin
                new_state = ST_I;
                l1_msg_d  = MSG_INVLINE;
              end
            end
            CMD_CLR: begin
              clr_idx_d = '0;
              fsm_d     = FSM_CLEAR;
            end
            default: ;
          endcase
          if (resp_valid_d) begin
            state_d[req_set][req_way] = new_state;
            state_out_d               = new_state;
          end
        end
      end

      FSM_MISS_WAIT: begin
        if (bus_done) begin
          if (miss_wr_q) begin
            new_state = ST_M;
          end else begin
            new_state = (snoop_hit || snoop_hitm) ? ST_S : ST_E;
          end
          state_d[miss_set_q][miss_way_q] = new_state;
          resp_valid_d = 1'b1;
          l1_msg_d     = MSG_SENDLINE;
          state_out_d  = new_state;
          fsm_d        = FSM_IDLE;
        end
      end

      FSM_CLEAR: begin
        state_d[clr_idx_q] = '0;
        if (clr_idx_q == LAST_SET) begin
          resp_valid_d = 1'b1;
          l1_msg_d     = MSG_INVLINE;
          state_out_d  = ST_I;
          fsm_d        = FSM_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end

      default: fsm_d = FSM_IDLE;
    endcase

    bus_valid_d = (bus_op_d != BUS_NULL);
  end

  // State register: reset drops any outstanding miss or clear silently.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fsm_q        <= FSM_IDLE;
      state_q      <= '0;
      miss_set_q   <= '0;
      miss_way_q   <= '0;
      miss_wr_q    <= 1'b0;
      clr_idx_q    <= '0;
      bus_valid_q  <= 1'b0;
      bus_op_q     <= BUS_NULL;
      resp_valid_q <= 1'b0;
      l1_msg_q     <= MSG_NULL;
      state_out_q  <= ST_I;
      err_q        <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      miss_set_q   <= miss_set_d;
      miss_way_q   <= miss_way_d;
      miss_wr_q    <= miss_wr_d;
      clr_idx_q    <= clr_idx_d;
      bus_valid_q  <= bus_valid_d;
      bus_op_q     <= bus_op_d;
      resp_valid_q <= resp_valid_d;
      l1_msg_q     <= l1_msg_d;
      state_out_q  <= state_out_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (fsm_q == FSM_IDLE);
  assign bus_valid  = bus_valid_q;
  assign bus_op     = bus_op_q;
  assign resp_valid = resp_valid_q;
  assign l1_msg     = l1_msg_q;
  assign state_out  = state_out_q;
  assign err        = err_q;
  assign dbg_state  = state_q[dbg_set][dbg_way];

endmodule
